// File: rtl/mp_alu_pkg.sv
// Shared constants for the multi-precision ALU controller: ALU opcodes,
// command encodings and the sequencer state type.
package mp_alu_pkg;

   localparam logic [3:0] ALU_NOP       = 4'd0;
   localparam logic [3:0] ALU_ADD_CARRY = 4'd2;
   localparam logic [3:0] ALU_AND       = 4'd6;
   localparam logic [3:0] ALU_NOT       = 4'd7;

   localparam logic [2:0] CMD_ADD = 3'd0;
   localparam logic [2:0] CMD_SUB = 3'd1;
   localparam logic [2:0] CMD_INC = 3'd2;
   localparam logic [2:0] CMD_AND = 3'd3;
   localparam logic [2:0] CMD_NOT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN_NOT = 2'd1,
      ST_RUN_OP  = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   function automatic logic op_supported(input logic [2:0] op);
      return (op <= CMD_NOT);
   endfunction

endpackage

// File: rtl/mp_alu_word_mux.sv
// Word slicing for the wide operands and word insertion into the wide result,
// both addressed by the current word index.
module mp_alu_word_mux #(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_WORDS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [BUS_WIDTH*NUM_WORDS-1:0] a_i,
   input  logic [BUS_WIDTH*NUM_WORDS-1:0] b_i,
   input  logic [BUS_WIDTH*NUM_WORDS-1:0] y_i,
   input  logic [IDX_W-1:0]               idx_i,
   input  logic [BUS_WIDTH-1:0]           word_i,
   output logic [BUS_WIDTH-1:0]           a_word_o,
   output logic [BUS_WIDTH-1:0]           b_word_o,
   output logic [BUS_WIDTH*NUM_WORDS-1:0] y_o
);

   assign a_word_o = a_i[int'(idx_i)*BUS_WIDTH +: BUS_WIDTH];
   assign b_word_o = b_i[int'(idx_i)*BUS_WIDTH +: BUS_WIDTH];

   always_comb begin
      y_o = y_i;
      y_o[int'(idx_i)*BUS_WIDTH +: BUS_WIDTH] = word_i;
   end

endmodule

// File: rtl/mp_alu_ctrl.sv
// Multi-precision command sequencer driving an external 8-bit ALU word by word.
// Optional MP_ALU_CTRL_PERF_CNT_EN adds saturating response/run-cycle counters.
module mp_alu_ctrl
   import mp_alu_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_WORDS = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           cmd_valid_i,
   output logic                           cmd_ready_o,
   input  logic [2:0]                     cmd_op_i,
   input  logic [BUS_WIDTH*NUM_WORDS-1:0] cmd_a_i,
   input  logic [BUS_WIDTH*NUM_WORDS-1:0] cmd_b_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [BUS_WIDTH*NUM_WORDS-1:0] rsp_y_o,
   output logic                           rsp_carry_o,
   output logic                           rsp_zero_o,
   output logic                           rsp_error_o,
   output logic [BUS_WIDTH-1:0]           alu_a_o,
   output logic [BUS_WIDTH-1:0]           alu_b_o,
   output logic                           alu_carry_in_o,
   output logic [3:0]                     alu_opcode_o,
   input  logic [BUS_WIDTH-1:0]           alu_y_i,
   input  logic                           alu_carry_out_i,
   input  logic                           alu_invalid_op_i
`ifdef MP_ALU_CTRL_PERF_CNT_EN
   ,
   output logic [15:0]                    perf_cmds_o,
   output logic [15:0]                    perf_passes_o
`endif
);

   localparam int W     = BUS_WIDTH * NUM_WORDS;
   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   carry_q, carry_d;
   logic [BUS_WIDTH-1:0]   temp_q, temp_d;
   logic [2:0]             op_q, op_d;
   logic [W-1:0]           a_q, a_d;
   logic [W-1:0]           b_q, b_d;
   logic [W-1:0]           rsp_y_q, rsp_y_d;
   logic                   rsp_carry_q, rsp_carry_d;
   logic                   rsp_error_q, rsp_error_d;

   logic [BUS_WIDTH-1:0]   a_word, b_word;
   logic [W-1:0]           y_merged;
   logic                   first_word, last_word;

   mp_alu_word_mux #(
      .BUS_WIDTH(BUS_WIDTH),
      .NUM_WORDS(NUM_WORDS),
      .IDX_W    (IDX_W)
   ) u_word_mux (
      .a_i     (a_q),
      .b_i     (b_q),
      .y_i     (rsp_y_q),
      .idx_i   (idx_q),
      .word_i  (alu_y_i),
      .a_word_o(a_word),
      .b_word_o(b_word),
      .y_o     (y_merged)
   );

   assign first_word  = (idx_q == '0);
   assign last_word   = (idx_q == IDX_LAST);
   assign cmd_ready_o = (state_q == ST_IDLE) && !reset_i;
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_y_o     = rsp_y_q;
   assign rsp_carry_o = rsp_carry_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_zero_o  = (rsp_y_q == '0);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         temp_q      <= '0;
         op_q        <= CMD_ADD;
         a_q         <= '0;
         b_q         <= '0;
         rsp_y_q     <= '0;
         rsp_carry_q <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         temp_q      <= temp_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_y_q     <= rsp_y_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   // SUB runs two passes per word: invert B[idx] into temp, then add it with
   // carry-in 1 on the lowest word; borrow is the inverted final carry.
   // Unsupported ops spend one idle RUN_OP cycle so they answer one cycle after accept.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      carry_d        = carry_q;
      temp_d         = temp_q;
      op_d           = op_q;
      a_d            = a_q;
      b_d            = b_q;
      rsp_y_d        = rsp_y_q;
      rsp_carry_d    = rsp_carry_q;
      rsp_error_d    = rsp_error_q;
      alu_opcode_o   = ALU_NOP;
      alu_a_o        = '0;
      alu_b_o        = '0;
      alu_carry_in_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               op_d        = cmd_op_i;
               a_d         = cmd_a_i;
               b_d         = cmd_b_i;
               idx_d       = '0;
               carry_d     = 1'b0;
               rsp_y_d     = '0;
               rsp_carry_d = 1'b0;
               rsp_error_d = !op_supported(cmd_op_i);
               state_d     = (cmd_op_i == CMD_SUB) ? ST_RUN_NOT : ST_RUN_OP;
            end
         end
         ST_RUN_NOT: begin
            alu_opcode_o = ALU_NOT;
            alu_a_o      = b_word;
            temp_d       = alu_y_i;
            if (alu_invalid_op_i) rsp_error_d = 1'b1;
            state_d      = ST_RUN_OP;
         end
         ST_RUN_OP: begin
            if (!op_supported(op_q)) begin
               state_d = ST_RESP;
            end else begin
               case (op_q)
                  CMD_ADD: begin
                     alu_opcode_o   = ALU_ADD_CARRY;
                     alu_a_o        = a_word;
                     alu_b_o        = b_word;
                     alu_carry_in_o = first_word ? 1'b0 : carry_q;
                  end
                  CMD_INC: begin
                     alu_opcode_o   = ALU_ADD_CARRY;
                     alu_a_o        = a_word;
                     alu_carry_in_o = first_word ? 1'b1 : carry_q;
                  end
                  CMD_SUB: begin
                     alu_opcode_o   = ALU_ADD_CARRY;
                     alu_a_o        = a_word;
                     alu_b_o        = temp_q;
                     alu_carry_in_o = first_word ? 1'b1 : carry_q;
                  end
                  CMD_AND: begin
                     alu_opcode_o = ALU_AND;
                     alu_a_o      = a_word;
                     alu_b_o      = b_word;
                  end
                  default: begin
                     alu_opcode_o = ALU_NOT;
                     alu_a_o      = a_word;
                  end
               endcase
               rsp_y_d = y_merged;
               carry_d = alu_carry_out_i;
               if (alu_invalid_op_i) rsp_error_d = 1'b1;
               if (last_word) begin
                  state_d = ST_RESP;
                  case (op_q)
                     CMD_ADD, CMD_INC: rsp_carry_d = alu_carry_out_i;
                     CMD_SUB:          rsp_carry_d = !alu_carry_out_i;
                     default:          rsp_carry_d = 1'b0;
                  endcase
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = (op_q == CMD_SUB) ? ST_RUN_NOT : ST_RUN_OP;
               end
            end
         end
         default: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
      endcase
   end

`ifdef MP_ALU_CTRL_PERF_CNT_EN
   logic [15:0] perf_cmds_q, perf_passes_q;

   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_cmds_q   <= '0;
         perf_passes_q <= '0;
      end else begin
         if (rsp_valid_o && rsp_ready_i && (perf_cmds_q != 16'hFFFF))
            perf_cmds_q <= perf_cmds_q + 16'd1;
         if (((state_q == ST_RUN_NOT) || (state_q == ST_RUN_OP)) && (perf_passes_q != 16'hFFFF))
            perf_passes_q <= perf_passes_q + 16'd1;
      end
   end

   assign perf_cmds_o   = perf_cmds_q;
   assign perf_passes_o = perf_passes_q;
`endif

endmodule

// File: tb/tb_mp_alu_ctrl.sv
// Directed bench for mp_alu_ctrl with a behavioural 8-bit ALU attached.
module tb_mp_alu_ctrl;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_y;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_error;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_carry_in;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_y;
   logic        alu_carry_out;
   logic        alu_invalid_op;
   logic        force_invalid;

   int checkCount = 0;
   int passCount  = 0;

   mp_alu_ctrl #(.BUS_WIDTH(8), .NUM_WORDS(4)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .cmd_valid_i     (cmd_valid),
      .cmd_ready_o     (cmd_ready),
      .cmd_op_i        (cmd_op),
      .cmd_a_i         (cmd_a),
      .cmd_b_i         (cmd_b),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .rsp_y_o         (rsp_y),
      .rsp_carry_o     (rsp_carry),
      .rsp_zero_o      (rsp_zero),
      .rsp_error_o     (rsp_error),
      .alu_a_o         (alu_a),
      .alu_b_o         (alu_b),
      .alu_carry_in_o  (alu_carry_in),
      .alu_opcode_o    (alu_opcode),
      .alu_y_i         (alu_y),
      .alu_carry_out_i (alu_carry_out),
      .alu_invalid_op_i(alu_invalid_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: ADD_CARRY=2, AND=6, NOT=7; opcodes >= 8 are invalid.
   always_comb begin
      alu_y          = 8'h00;
      alu_carry_out  = 1'b0;
      alu_invalid_op = force_invalid || (alu_opcode >= 4'd8);
      case (alu_opcode)
         4'd2:    {alu_carry_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
         4'd6:    alu_y = alu_a & alu_b;
         4'd7:    alu_y = ~alu_a;
         default: alu_y = 8'h00;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Issues one command, waits for the response and checks it; leaves it pending.
   task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expY, input logic expC,
                                input logic expErr, input int expLat);
      int lat;
      @(negedge clk);
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, "_y"}, 64'(rsp_y), 64'(expY));
      checkOutput({tag, "_carry"}, 64'(rsp_carry), 64'(expC));
      checkOutput({tag, "_zero"}, 64'(rsp_zero), 64'(expY == 32'h0));
      checkOutput({tag, "_error"}, 64'(rsp_error), 64'(expErr));
   endtask

   task automatic drainResponse(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
      checkOutput({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      reset         = 1'b1;
      cmd_valid     = 1'b0;
      cmd_op        = 3'd0;
      cmd_a         = 32'h0;
      cmd_b         = 32'h0;
      rsp_ready     = 1'b0;
      force_invalid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_y", 64'(rsp_y), 64'd0);
      checkOutput("reset_rsp_carry", 64'(rsp_carry), 64'd0);
      checkOutput("reset_rsp_error", 64'(rsp_error), 64'd0);
      checkOutput("reset_alu_opcode", 64'(alu_opcode), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus("add_small", 3'd0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 4);
      drainResponse("add_small");
      applyStimulus("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4);
      drainResponse("add_wrap");
      applyStimulus("sub_borrow", 3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 8);
      drainResponse("sub_borrow");
      applyStimulus("sub_plain", 3'd1, 32'h00001234, 32'h00000234, 32'h00001000, 1'b0, 1'b0, 8);
      drainResponse("sub_plain");
      applyStimulus("inc", 3'd2, 32'h00FFFFFF, 32'hDEADBEEF, 32'h01000000, 1'b0, 1'b0, 4);
      drainResponse("inc");
      applyStimulus("and", 3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 4);
      drainResponse("and");
      applyStimulus("not", 3'd4, 32'h0F0F0F0F, 32'h12345678, 32'hF0F0F0F0, 1'b0, 1'b0, 4);
      drainResponse("not");
      applyStimulus("bad_op", 3'd6, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1'b1, 1);
      drainResponse("bad_op");

      force_invalid = 1'b1;
      applyStimulus("alu_invalid", 3'd0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b1, 4);
      force_invalid = 1'b0;
      drainResponse("alu_invalid");
      applyStimulus("err_cleared", 3'd0, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, 1'b0, 4);
      drainResponse("err_cleared");

      applyStimulus("stall", 3'd0, 32'h00000005, 32'h00000006, 32'h0000000B, 1'b0, 1'b0, 4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_valid", 64'(rsp_valid), 64'd1);
         checkOutput("stall_y", 64'(rsp_y), 64'h0000000B);
         checkOutput("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      drainResponse("stall");

      @(negedge clk);
      cmd_op    = 3'd1;
      cmd_a     = 32'h00000010;
      cmd_b     = 32'h00000001;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midreset_idle", 64'(cmd_ready), 64'd1);
      checkOutput("midreset_rsp_y", 64'(rsp_y), 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("midreset_no_rsp", 64'(rsp_valid), 64'd0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
